// File: rtl/ysyx_23060020_ifu.sv
// ysyx_23060020_ifu: single-outstanding instruction fetch with flush, misalignment and timeout handling
module ysyx_23060020_ifu #(
    parameter int XLEN = 32,
    parameter int TIMEOUT = 255,
    parameter logic [XLEN-1:0] NOP = 'h13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instw,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic            busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;
    state_t state, state_d;
    logic [XLEN-1:0] addr_q, addr_d, inst_q, inst_d;
    logic fault_q, fault_d, drop_pending, drop_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic misal;
    assign misal = |addr_q[1:0];
    // a stale response from an abandoned request must land before a new request goes out
    assign req_valid = (state == REQ) && !misal && !drop_pending;
    assign req_addr = addr_q;
    assign inst_valid = state == VALID;
    assign instw = inst_q;
    assign inst_pc = addr_q;
    assign inst_fault = fault_q;
    assign busy = (state != IDLE) || drop_pending;
    always_comb begin
        state_d = state;
        addr_d = addr_q;
        inst_d = inst_q;
        fault_d = fault_q;
        drop_d = drop_pending && !(rsp_valid && state != WAIT);
        tcnt_d = tcnt;
        case (state)
            IDLE: if (fetch_en && !flush) begin
                addr_d = pc;
                state_d = REQ;
            end
            REQ: if (flush) begin
                state_d = IDLE;
                if (req_valid && req_ready) drop_d = 1'b1;
            end else if (misal) begin
                state_d = VALID;
                inst_d = NOP;
                fault_d = 1'b1;
            end else if (req_valid && req_ready) begin
                state_d = WAIT;
                tcnt_d = '0;
            end
            WAIT: if (flush) begin
                state_d = IDLE;
                drop_d = !rsp_valid;
            end else if (rsp_valid) begin
                state_d = VALID;
                inst_d = rsp_err ? NOP : rsp_data;
                fault_d = rsp_err;
            end else if (tcnt == TMAX) begin
                state_d = VALID;
                inst_d = NOP;
                fault_d = 1'b1;
                drop_d = 1'b1;
            end else begin
                tcnt_d = tcnt + 1'b1;
            end
            default: if (flush || inst_ready) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr_q <= '0;
            inst_q <= '0;
            fault_q <= 1'b0;
            drop_pending <= 1'b0;
            tcnt <= '0;
        end else begin
            state <= state_d;
            addr_q <= addr_d;
            inst_q <= inst_d;
            fault_q <= fault_d;
            drop_pending <= drop_d;
            tcnt <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// tb_ysyx_23060020_ifu: scoreboard bench; expected instructions queued at fetch, checked at consume
module tb_ysyx_23060020_ifu;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clk, rst, fetch_en, flush, req_valid, req_ready, rsp_valid, rsp_err;
    logic inst_valid, inst_ready, inst_fault, busy;
    logic [31:0] pc, req_addr, rsp_data, instw, inst_pc;
    logic [64:0] exp_q[$];
    int n_cmp = 0, n_bad = 0;
    ysyx_23060020_ifu #(.XLEN(32), .TIMEOUT(4), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instw(instw),
        .inst_pc(inst_pc), .inst_fault(inst_fault), .busy(busy)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        chk("excl", {31'b0, inst_valid & req_valid}, 0);
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) chk("unexp_inst", instw, 32'hxxxxxxxx);
            else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("sb_instw", instw, e[31:0]);
                chk("sb_pc", inst_pc, e[63:32]);
                chk("sb_fault", {31'b0, inst_fault}, {31'b0, e[64]});
            end
        end
    end
    task automatic fetch(input logic [31:0] a, input int rd, input int sd, input logic [31:0] d,
                         input logic e, input int cd);
        logic mis, f;
        logic [31:0] w;
        mis = a[1:0] != 2'b00;
        f = mis || e;
        w = f ? NOP : d;
        exp_q.push_back({f, a, w});
        fetch_en = 1; pc = a; step(); fetch_en = 0;
        if (mis) begin
            chk("mis_req", {31'b0, req_valid}, 0);
            step();
        end else begin
            repeat (rd) begin
                chk("bp_valid", {31'b0, req_valid}, 1);
                chk("bp_addr", req_addr, a);
                step();
            end
            req_ready = 1;
            chk("req_valid", {31'b0, req_valid}, 1);
            chk("req_addr", req_addr, a);
            step(); req_ready = 0;
            repeat (sd) begin
                chk("wait_iv", {31'b0, inst_valid}, 0);
                step();
            end
            rsp_valid = 1; rsp_data = d; rsp_err = e; step(); rsp_valid = 0; rsp_err = 0;
        end
        repeat (cd) begin
            chk("hold_iv", {31'b0, inst_valid}, 1);
            chk("hold_w", instw, w);
            step();
        end
        chk("iv", {31'b0, inst_valid}, 1);
        chk("fault", {31'b0, inst_fault}, {31'b0, f});
        inst_ready = 1; step(); inst_ready = 0;
        chk("idle_iv", {31'b0, inst_valid}, 0);
        chk("idle_busy", {31'b0, busy}, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int n;
        rst = 1; fetch_en = 0; pc = 0; flush = 0; req_ready = 0;
        rsp_valid = 0; rsp_data = 0; rsp_err = 0; inst_ready = 0;
        step(); step(); rst = 0;
        chk("rst_out", {req_valid, inst_valid, inst_fault, busy}, 0);
        chk("rst_instw", instw, 0);
        chk("rst_pc", inst_pc, 0);
        fetch(32'h80000000, 0, 0, 32'h00100073, 0, 0);
        fetch(32'h80000004, 4, 3, 32'h12345678, 0, 2);
        fetch(32'h80000002, 0, 0, 32'hAAAAAAAA, 0, 1);
        fetch(32'h80000008, 0, 1, 32'hFFFFFFFF, 1, 0);
        // timeout, then the late response must be swallowed
        exp_q.push_back({1'b1, 32'h80000010, NOP});
        fetch_en = 1; pc = 32'h80000010; step(); fetch_en = 0;
        req_ready = 1; step(); req_ready = 0;
        n = 0;
        while (!inst_valid && n < 20) begin step(); n++; end
        chk("to_arrive", {31'b0, inst_valid}, 1);
        inst_ready = 1; step(); inst_ready = 0;
        chk("to_drop_busy", {31'b0, busy}, 1);
        fetch_en = 1; pc = 32'h80000020; step(); fetch_en = 0;
        req_ready = 1;
        repeat (3) begin chk("stale_hold", {31'b0, req_valid}, 0); step(); end
        rsp_valid = 1; rsp_data = 32'hDEADBEEF; step(); rsp_valid = 0;
        chk("post_stale_req", {31'b0, req_valid}, 1);
        chk("post_stale_addr", req_addr, 32'h80000020);
        step(); req_ready = 0;
        exp_q.push_back({1'b0, 32'h80000020, 32'h0000AAAA});
        rsp_valid = 1; rsp_data = 32'h0000AAAA; step(); rsp_valid = 0;
        chk("to2_iv", {31'b0, inst_valid}, 1);
        inst_ready = 1; step(); inst_ready = 0;
        chk("to2_busy", {31'b0, busy}, 0);
        // flush while waiting
        fetch_en = 1; pc = 32'h80000030; step(); fetch_en = 0;
        req_ready = 1; step(); req_ready = 0;
        flush = 1; step(); flush = 0;
        chk("fl_iv", {31'b0, inst_valid}, 0);
        chk("fl_busy", {31'b0, busy}, 1);
        step();
        rsp_valid = 1; rsp_data = 32'hBADBAD00; step(); rsp_valid = 0;
        chk("fl_clr", {31'b0, busy}, 0);
        fetch(32'h80000040, 0, 0, 32'h00000517, 0, 0);
        // reset during REQ
        fetch_en = 1; pc = 32'h80000050; step(); fetch_en = 0;
        chk("rq_valid", {31'b0, req_valid}, 1);
        rst = 1; step(); rst = 0;
        chk("mrst_out", {req_valid, inst_valid, inst_fault, busy}, 0);
        chk("mrst_instw", instw, 0);
        chk("mrst_pc", inst_pc, 0);
        fetch(32'h80000060, 1, 2, 32'h00008067, 0, 1);
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
